// File: rtl/vx_warp_ctl_sched_if.sv
// ---------------------------------------------------------------------------
// vx_warp_ctl_sched_if
// Warp-control request bus between the instruction pipeline (master) and the
// warp-control scheduler (slave).
//
// Signals:
//   ctl_valid     request present (master -> slave)
//   ctl_ready     request accepted on ctl_valid && ctl_ready (slave -> master)
//   ctl_wid       issuing warp
//   tmc_valid     thread-mask change; tmc_mask is the new mask
//   wspawn_valid  warp spawn; wspawn_num is the total warp count, wspawn_pc
//                 the start PC for the spawned warps
//   bar_valid     barrier arrival; bar_id selects the slot, bar_size_m1 is the
//                 participant count minus one
// ---------------------------------------------------------------------------
interface vx_warp_ctl_sched_if #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4
);
  localparam int NW_BITS = $clog2(NUM_WARPS);
  // A single barrier slot still needs a one-bit id port.
  localparam int NB_BITS = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1;

  logic                   ctl_valid;
  logic                   ctl_ready;
  logic [NW_BITS-1:0]     ctl_wid;
  logic                   tmc_valid;
  logic [NUM_THREADS-1:0] tmc_mask;
  logic                   wspawn_valid;
  logic [NW_BITS:0]       wspawn_num;
  logic [31:0]            wspawn_pc;
  logic                   bar_valid;
  logic [NB_BITS-1:0]     bar_id;
  logic [NW_BITS-1:0]     bar_size_m1;

  modport master (
    output ctl_valid, ctl_wid,
    output tmc_valid, tmc_mask,
    output wspawn_valid, wspawn_num, wspawn_pc,
    output bar_valid, bar_id, bar_size_m1,
    input  ctl_ready
  );

  modport slave (
    input  ctl_valid, ctl_wid,
    input  tmc_valid, tmc_mask,
    input  wspawn_valid, wspawn_num, wspawn_pc,
    input  bar_valid, bar_id, bar_size_m1,
    output ctl_ready
  );
endinterface

// File: rtl/vx_warp_ctl_sched.sv
// ---------------------------------------------------------------------------
// vx_warp_ctl_sched
// Warp-control scheduler: applies thread-mask changes, sequences warp spawns
// one warp per cycle, and tracks barrier arrivals / stalls.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   ctl            warp-control request bus (slave side)
//   active_warps   per-warp active flag
//   stalled_warps  per-warp barrier-stall flag
//   thread_masks   per-warp thread mask, warp w at [w*NUM_THREADS +: NUM_THREADS]
//   spawn_valid    one-cycle pulse per spawned warp
//   spawn_wid      warp being spawned
//   spawn_pc       start PC of the warp being spawned
// ---------------------------------------------------------------------------
module vx_warp_ctl_sched #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_THREADS  = 4,
  parameter int NUM_BARRIERS = 4,
  localparam int NW_BITS     = $clog2(NUM_WARPS),
  localparam int NB_BITS     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  vx_warp_ctl_sched_if.slave               ctl,
  output logic [NUM_WARPS-1:0]             active_warps,
  output logic [NUM_WARPS-1:0]             stalled_warps,
  output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
  output logic                             spawn_valid,
  output logic [NW_BITS-1:0]               spawn_wid,
  output logic [31:0]                      spawn_pc
);

  localparam logic [NW_BITS:0]       WARP_CNT = (NW_BITS+1)'(NUM_WARPS);
  localparam logic [NUM_THREADS-1:0] THREAD0  = NUM_THREADS'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SPAWN = 1'b1
  } state_t;

  state_t                 state_reg;
  logic                   ctl_ready_reg;
  logic                   spawn_valid_reg;
  logic [NW_BITS-1:0]     spawn_wid_reg;   // doubles as the spawn counter
  logic [NW_BITS-1:0]     spawn_last_reg;  // last warp id to spawn (N-1)
  logic [31:0]            spawn_pc_reg;
  logic [NUM_WARPS-1:0]   active_reg;
  logic [NUM_THREADS-1:0] masks_reg [NUM_WARPS];

  logic [NUM_WARPS-1:0]   stalled_reg;
  logic [NW_BITS-1:0]     bar_cnt_reg  [NUM_BARRIERS];
  logic [NUM_WARPS-1:0]   bar_wait_reg [NUM_BARRIERS];

  // Request decode: exactly one action per accepted request, tmc > wspawn > bar.
  logic               accept;
  logic               do_tmc;
  logic               do_spawn;
  logic               do_bar;
  logic               spawn_go;
  logic [NW_BITS-1:0] spawn_last;

  assign accept   = ctl.ctl_valid && ctl_ready_reg;
  assign do_tmc   = accept && ctl.tmc_valid;
  assign do_spawn = accept && !ctl.tmc_valid && ctl.wspawn_valid;
  assign do_bar   = accept && !ctl.tmc_valid && !ctl.wspawn_valid && ctl.bar_valid;

  // N = min(wspawn_num, NUM_WARPS); warp 0 is the caller, so only N >= 2
  // produces any spawn. The last spawned id is N-1, which always fits NW_BITS.
  assign spawn_go   = ctl.wspawn_num > (NW_BITS+1)'(1);
  assign spawn_last = (ctl.wspawn_num >= WARP_CNT) ? {NW_BITS{1'b1}}
                                                   : ctl.wspawn_num[NW_BITS-1:0] - NW_BITS'(1);

  // -------------------------------------------------------------------------
  // Spawn FSM plus per-warp active flag and thread mask. TMC can only occur
  // in IDLE (ctl_ready is low in SPAWN), so the two writers never collide.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      ctl_ready_reg   <= 1'b1;
      spawn_valid_reg <= 1'b0;
      spawn_wid_reg   <= '0;
      spawn_last_reg  <= '0;
      spawn_pc_reg    <= '0;
      active_reg      <= NUM_WARPS'(1);
      for (int i = 0; i < NUM_WARPS; i++) begin
        masks_reg[i] <= (i == 0) ? {NUM_THREADS{1'b1}} : '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_tmc) begin
            masks_reg[ctl.ctl_wid]  <= ctl.tmc_mask;
            active_reg[ctl.ctl_wid] <= |ctl.tmc_mask;
          end else if (do_spawn && spawn_go) begin
            // Outputs for warp 1 are loaded now so the first pulse appears
            // on the cycle right after acceptance.
            state_reg       <= SPAWN;
            ctl_ready_reg   <= 1'b0;
            spawn_valid_reg <= 1'b1;
            spawn_wid_reg   <= NW_BITS'(1);
            spawn_last_reg  <= spawn_last;
            spawn_pc_reg    <= ctl.wspawn_pc;
          end
        end
        SPAWN: begin
          // The warp currently on spawn_wid is committed at the end of its
          // pulse cycle; existing state of that warp is overwritten.
          active_reg[spawn_wid_reg] <= 1'b1;
          masks_reg[spawn_wid_reg]  <= THREAD0;
          if (spawn_wid_reg == spawn_last_reg) begin
            state_reg       <= IDLE;
            ctl_ready_reg   <= 1'b1;
            spawn_valid_reg <= 1'b0;
          end else begin
            spawn_wid_reg <= spawn_wid_reg + NW_BITS'(1);
          end
        end
        default: begin
          state_reg     <= IDLE;
          ctl_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Barrier slots. An arrival either joins the slot (count+1, stall) or, when
  // the count already equals size-1, releases every waiting warp of that slot
  // without stalling the arriving warp.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      stalled_reg <= '0;
      for (int i = 0; i < NUM_BARRIERS; i++) begin
        bar_cnt_reg[i]  <= '0;
        bar_wait_reg[i] <= '0;
      end
    end else if (do_bar) begin
      if (bar_cnt_reg[ctl.bar_id] == ctl.bar_size_m1) begin
        stalled_reg              <= stalled_reg & ~bar_wait_reg[ctl.bar_id];
        bar_cnt_reg[ctl.bar_id]  <= '0;
        bar_wait_reg[ctl.bar_id] <= '0;
      end else begin
        bar_cnt_reg[ctl.bar_id]               <= bar_cnt_reg[ctl.bar_id] + NW_BITS'(1);
        bar_wait_reg[ctl.bar_id][ctl.ctl_wid] <= 1'b1;
        stalled_reg[ctl.ctl_wid]              <= 1'b1;
      end
    end
  end

  // Output packing
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WARPS; gi++) begin : g_mask_out
      assign thread_masks[gi*NUM_THREADS +: NUM_THREADS] = masks_reg[gi];
    end
  endgenerate

  assign ctl.ctl_ready   = ctl_ready_reg;
  assign active_warps    = active_reg;
  assign stalled_warps   = stalled_reg;
  assign spawn_valid     = spawn_valid_reg;
  assign spawn_wid       = spawn_wid_reg;
  assign spawn_pc        = spawn_pc_reg;

endmodule

// File: tb/tb_vx_warp_ctl_sched.sv
// ---------------------------------------------------------------------------
// tb_vx_warp_ctl_sched
// Scoreboard bench: the driver applies each request to a behavioural model
// and queues the expected warp state and spawn pulses; a monitor compares
// them against the DUT whenever it presents a spawn pulse or is ready again.
// ---------------------------------------------------------------------------
module tb_vx_warp_ctl_sched;
  localparam int NW  = 4;
  localparam int NT  = 4;
  localparam int NB  = 4;
  localparam int NWB = $clog2(NW);
  localparam int NBB = $clog2(NB);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NW-1:0]    active_warps;
  logic [NW-1:0]    stalled_warps;
  logic [NW*NT-1:0] thread_masks;
  logic             spawn_valid;
  logic [NWB-1:0]   spawn_wid;
  logic [31:0]      spawn_pc;

  vx_warp_ctl_sched_if #(.NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_BARRIERS(NB)) cif ();

  vx_warp_ctl_sched #(.NUM_WARPS(NW), .NUM_THREADS(NT), .NUM_BARRIERS(NB)) dut (
    .clk           (clk),
    .reset         (reset),
    .ctl           (cif),
    .active_warps  (active_warps),
    .stalled_warps (stalled_warps),
    .thread_masks  (thread_masks),
    .spawn_valid   (spawn_valid),
    .spawn_wid     (spawn_wid),
    .spawn_pc      (spawn_pc)
  );

  typedef struct {
    logic [NW-1:0]    act;
    logic [NW-1:0]    stl;
    logic [NW*NT-1:0] msk;
  } snap_t;

  typedef struct {
    int          wid;
    logic [31:0] pc;
  } spw_t;

  snap_t state_q[$];
  spw_t  spawn_q[$];

  int checks = 0;
  int errors = 0;

  // Behavioural model
  bit          m_act   [NW];
  logic [NT-1:0] m_mask [NW];
  bit          m_stall [NW];
  int          m_cnt   [NB];
  bit          m_wait  [NB][NW];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int w = 0; w < NW; w++) begin
      m_act[w]   = (w == 0);
      m_mask[w]  = (w == 0) ? {NT{1'b1}} : '0;
      m_stall[w] = 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      m_cnt[b] = 0;
      for (int w = 0; w < NW; w++) m_wait[b][w] = 1'b0;
    end
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    for (int w = 0; w < NW; w++) begin
      s.act[w] = m_act[w];
      s.stl[w] = m_stall[w];
      s.msk[w*NT +: NT] = m_mask[w];
    end
    return s;
  endfunction

  // Returns the number of spawn cycles the request should produce.
  function automatic int model_apply(bit t, logic [NT-1:0] m, bit s, int num, logic [31:0] pc,
                                     bit b, int bid, int bsz, int wid);
    int n;
    if (t) begin
      m_mask[wid] = m;
      m_act[wid]  = (m != 0);
      return 0;
    end
    if (s) begin
      n = (num < NW) ? num : NW;
      for (int i = 1; i < n; i++) begin
        spw_t e;
        m_act[i]  = 1'b1;
        m_mask[i] = NT'(1);
        e.wid = i;
        e.pc  = pc;
        spawn_q.push_back(e);
      end
      return (n >= 2) ? n - 1 : 0;
    end
    if (b) begin
      if (m_cnt[bid] == bsz) begin
        for (int w = 0; w < NW; w++) begin
          if (m_wait[bid][w]) m_stall[w] = 1'b0;
          m_wait[bid][w] = 1'b0;
        end
        m_cnt[bid] = 0;
      end else begin
        m_cnt[bid] = (m_cnt[bid] + 1) % NW;
        m_wait[bid][wid] = 1'b1;
        m_stall[wid] = 1'b1;
      end
    end
    return 0;
  endfunction

  task automatic drive_req(bit t, logic [NT-1:0] m, bit s, int num, logic [31:0] pc,
                           bit b, int bid, int bsz, int wid);
    cif.ctl_valid    = 1'b1;
    cif.ctl_wid      = NWB'(wid);
    cif.tmc_valid    = t;
    cif.tmc_mask     = m;
    cif.wspawn_valid = s;
    cif.wspawn_num   = (NWB+1)'(num);
    cif.wspawn_pc    = pc;
    cif.bar_valid    = b;
    cif.bar_id       = NBB'(bid);
    cif.bar_size_m1  = NWB'(bsz);
  endtask

  task automatic clear_req();
    cif.ctl_valid    = 1'b0;
    cif.tmc_valid    = 1'b0;
    cif.wspawn_valid = 1'b0;
    cif.bar_valid    = 1'b0;
  endtask

  task automatic send(bit t, logic [NT-1:0] m, bit s, int num, logic [31:0] pc,
                      bit b, int bid, int bsz, int wid);
    int busy;
    int exp_busy;
    busy = 0;
    @(negedge clk);
    while (cif.ctl_ready !== 1'b1 && busy < 64) begin
      busy++;
      @(negedge clk);
    end
    chk("ready_before_req", cif.ctl_ready, 1'b1);
    drive_req(t, m, s, num, pc, b, bid, bsz, wid);
    @(posedge clk);
    #1;
    clear_req();
    exp_busy = model_apply(t, m, s, num, pc, b, bid, bsz, wid);
    state_q.push_back(model_snap());
    $display("req t=%0d m=%0h s=%0d num=%0d pc=%08h b=%0d bid=%0d bsz=%0d wid=%0d",
             t, m, s, num, pc, b, bid, bsz, wid);
    busy = 0;
    @(negedge clk);
    while (cif.ctl_ready !== 1'b1 && busy < 64) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", 64'(busy), 64'(exp_busy));
  endtask

  // Monitor: spawn pulses and post-request warp state
  initial begin
    forever begin
      @(negedge clk);
      if (spawn_valid === 1'b1) begin
        if (spawn_q.size() == 0) begin
          chk("spawn_unexpected", spawn_valid, 1'b0);
        end else begin
          spw_t e;
          e = spawn_q.pop_front();
          chk("spawn_wid", spawn_wid, 64'(e.wid));
          chk("spawn_pc", spawn_pc, e.pc);
        end
      end
      if (cif.ctl_ready === 1'b1 && state_q.size() > 0) begin
        snap_t s;
        s = state_q.pop_front();
        chk("active_warps", active_warps, s.act);
        chk("stalled_warps", stalled_warps, s.stl);
        chk("thread_masks", thread_masks, s.msk);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] apc;
    clear_req();
    cif.ctl_wid     = '0;
    cif.tmc_mask    = '0;
    cif.wspawn_num  = '0;
    cif.wspawn_pc   = '0;
    cif.bar_id      = '0;
    cif.bar_size_m1 = '0;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    state_q.push_back(model_snap());
    @(negedge clk);
    chk("rst_spawn_valid", spawn_valid, 1'b0);
    chk("rst_spawn_wid", spawn_wid, '0);
    chk("rst_spawn_pc", spawn_pc, '0);
    chk("rst_ctl_ready", cif.ctl_ready, 1'b1);

    // Thread-mask changes
    send(1, 4'b0011, 0, 0, 0, 0, 0, 0, 0);
    send(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
    // Spawns: full, degenerate, clamped
    send(0, 0, 1, 4, 32'h8000_0100, 0, 0, 0, 0);
    send(0, 0, 1, 1, 32'h1111_1111, 0, 0, 0, 0);
    send(0, 0, 1, 0, 32'h2222_2222, 0, 0, 0, 0);
    send(0, 0, 1, 7, 32'h3333_3333, 0, 0, 0, 0);
    // Barrier 2, three participants; then immediate release
    send(0, 0, 0, 0, 0, 1, 2, 2, 1);
    send(0, 0, 0, 0, 0, 1, 2, 2, 3);
    send(0, 0, 0, 0, 0, 1, 2, 2, 0);
    send(0, 0, 0, 0, 0, 1, 0, 0, 2);
    // All three request kinds at once: only TMC
    send(1, 4'b0101, 1, 4, 32'h4444_4444, 1, 1, 1, 2);

    // Reset in the middle of a four-warp spawn
    @(negedge clk);
    apc = 32'h1234_5678;
    drive_req(0, 0, 1, 4, apc, 0, 0, 0, 0);
    @(posedge clk);
    #1 clear_req();
    begin
      spw_t e;
      e.pc = apc;
      e.wid = 1; spawn_q.push_back(e);
      e.wid = 2; spawn_q.push_back(e);
    end
    $display("req spawn num=4 pc=%08h with reset after second pulse", apc);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    state_q.push_back(model_snap());
    repeat (6) @(negedge clk);
    chk("abort_ready", cif.ctl_ready, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      bit t, s, b;
      t = ($urandom_range(0, 3) == 0);
      s = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 1) == 1);
      send(t, NT'($urandom_range(0, (1 << NT) - 1)), s, $urandom_range(0, 7),
           $urandom, b, $urandom_range(0, NB - 1), $urandom_range(0, NW - 1),
           $urandom_range(0, NW - 1));
    end

    repeat (5) @(negedge clk);
    chk("spawn_q_drained", 64'(spawn_q.size()), 64'd0);
    chk("state_q_drained", 64'(state_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_warp_ctl_sched.md
VX_WARP_CTL_SCHED -- requirements
Module: VX_warp_ctl_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of hardware warps (power of 2, >=2).
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter NUM_BARRIERS, default 4, number of barrier slots (power of 2).
REQ-004 SHALL define NW_BITS = log2(NUM_WARPS) and NB_BITS = log2(NUM_BARRIERS).
REQ-005 SHALL have a single clock and a synchronous, active-high reset.
REQ-006 clk  input  1  clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 ctl_valid  input  1  warp-control request present.
REQ-009 ctl_ready  output  1  request accepted when ctl_valid && ctl_ready.
REQ-010 ctl_wid  input  NW_BITS  issuing warp.
REQ-011 tmc_valid / tmc_mask  input  1 / NUM_THREADS  thread-mask change and new mask.
REQ-012 wspawn_valid / wspawn_num / wspawn_pc  input  1 / NW_BITS+1 / 32  spawn request, total warp count, start PC.
REQ-013 bar_valid / bar_id / bar_size_m1  input  1 / NB_BITS / NW_BITS  barrier arrival, slot, participants minus one.
REQ-014 active_warps  output  NUM_WARPS  per-warp active flag.
REQ-015 stalled_warps  output  NUM_WARPS  per-warp barrier-stall flag.
REQ-016 thread_masks  output  NUM_WARPS*NUM_THREADS  per-warp thread mask; warp w occupies bits [w*NUM_THREADS +: NUM_THREADS].
REQ-017 spawn_valid / spawn_wid / spawn_pc  output  1 / NW_BITS / 32  one-cycle pulse per spawned warp.

Function
REQ-018 Request priority SHALL be tmc > wspawn > bar; only the highest-priority valid field of an accepted request SHALL take effect.
REQ-019 All state updates from an accepted request SHALL be visible on outputs the cycle after acceptance.
REQ-020 TMC SHALL write tmc_mask into thread_masks[ctl_wid]; if tmc_mask == 0, active_warps[ctl_wid] SHALL clear, otherwise it SHALL set.
REQ-021 FSM states SHALL be IDLE and SPAWN; ctl_ready SHALL be 1 in IDLE and 0 in SPAWN.
REQ-022 Accepted wspawn SHALL compute N = min(wspawn_num, NUM_WARPS); if N <= 1, the request SHALL be a no-op and the FSM SHALL stay in IDLE.
REQ-023 For N >= 2, the FSM SHALL enter SPAWN, latch wspawn_pc, and set the spawn counter to 1.
REQ-024 Each SPAWN cycle SHALL pulse spawn_valid with spawn_wid = counter and spawn_pc = the latched PC.
REQ-025 In the same SPAWN cycle, active_warps[counter] SHALL set and thread_masks[counter] SHALL be set to thread 0 only; the counter SHALL then increment.
REQ-026 After the cycle spawning warp N-1, the FSM SHALL return to IDLE; warps 1..N-1 SHALL spawn on cycles T+1..T+N-1 for acceptance at cycle T.
REQ-027 Spawn SHALL overwrite the state of already-active target warps; it SHALL NOT alter the stalled or barrier state of any warp.
REQ-028 Per barrier slot, the block SHALL hold an arrival count (NW_BITS wide) and a waiting mask (NUM_WARPS wide).
REQ-029 A barrier arrival with count[bar_id] != bar_size_m1 SHALL increment count, set waiting[bar_id][ctl_wid], and set stalled_warps[ctl_wid].
REQ-030 A barrier arrival with count[bar_id] == bar_size_m1 SHALL clear stalled_warps for all waiting[bar_id] bits and clear count and waiting for that slot; the arriving warp SHALL NOT stall.
REQ-031 bar_size_m1 == 0 SHALL therefore release immediately with no stall.
REQ-032 Barrier slots SHALL be independent; a release of one slot SHALL NOT affect the others.
REQ-033 TMC deactivation SHALL NOT modify barrier or stall state.

Reset
REQ-034 On reset: active_warps = 1 (warp 0 only), thread_masks[0] = all ones, other thread_masks = 0.
REQ-035 On reset: stalled_warps = 0, all barrier counts and waiting masks = 0, FSM = IDLE, spawn_valid = 0, spawn_wid = 0, spawn_pc = 0, ctl_ready = 1 from the first cycle after reset.
REQ-036 Reset during SPAWN SHALL abort the spawn; no spawn_valid pulse SHALL follow reset deassertion.

Verification
REQ-037 Reset, then TMC from wid 0 with mask 4'b0011 -> thread_masks[0] = 0011 and active_warps = 0001 next cycle; a later mask of 0 -> active_warps = 0000.
REQ-038 wspawn_num = 4, pc = 0x80000100, accepted at T -> spawn_valid pulses at T+1..T+3 with wid 1, 2, 3; ctl_ready low T+1..T+3, high at T+4; active_warps = 1111.
REQ-039 wspawn_num = 1 and wspawn_num = 0 -> no spawn_valid, ctl_ready stays 1; wspawn_num = 7 with NUM_WARPS = 4 -> exactly 3 spawns.
REQ-040 Barrier 2 with bar_size_m1 = 2, arrivals from wids 1, 3, 0 -> stalled_warps = 0010, then 1010, then 0000 the cycle after the third arrival; barrier 0 state unchanged throughout.
REQ-041 Request with tmc_valid, wspawn_valid and bar_valid all set -> only the TMC takes effect, with no spawn and no stall; reset asserted at T+2 of a 4-warp spawn -> state returns to reset values and no further spawn pulses occur.
